// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package wb_arb_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int IDX_W_DEF  = 6;
  localparam int SQ_W       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    STARVED = 2'd2
  } arb_state_e;
endpackage

// File: rtl/wb_lu_buffer.sv
// Small FIFO for long-latency results; each entry carries valid/dead bits so
// younger pipeline writes can kill stale results in place.
module wb_lu_buffer import wb_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1,
  localparam int KILL_W = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [IDX_W-1:0]  push_index_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [IDX_W-1:0]  kill_index_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              head_dead_o,
  output logic [IDX_W-1:0]  head_index_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [KILL_W-1:0] kill_cnt_o
);
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [IDX_W-1:0]  index_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  dead_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  kill_hit;
  logic              push_kill;

  // Only live entries count as a squash; re-killing a dead entry is free.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
    assign kill_hit[gi] = kill_i && valid_q[gi] && !dead_q[gi] &&
                          (index_q[gi] == kill_index_i);
  end

  assign push_kill = push_i && kill_i && (push_index_i == kill_index_i);

  always_comb begin
    kill_cnt_o = KILL_W'(push_kill);
    for (int i = 0; i < DEPTH; i++) begin
      kill_cnt_o = kill_cnt_o + KILL_W'(kill_hit[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      dead_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (wr_ptr_q == PTR_W'(i))) begin
          valid_q[i] <= 1'b1;
          dead_q[i]  <= push_kill;
        end else if (pop_i && (rd_ptr_q == PTR_W'(i))) begin
          valid_q[i] <= 1'b0;
        end else if (kill_hit[i]) begin
          dead_q[i] <= 1'b1;
        end
      end
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      data_q[wr_ptr_q]  <= push_data_i;
      index_q[wr_ptr_q] <= push_index_i;
    end
  end

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_dead_o  = dead_q[rd_ptr_q];
  assign head_index_o = index_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: write-back stage always wins, buffered
// long-latency results drain into idle slots, starvation raises pipe_stall.
module wb_port_arbiter import wb_arb_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IDX_W        = IDX_W_DEF,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wb_en,
  input  logic [IDX_W-1:0]  pipe_wb_index,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              lu_valid,
  input  logic [IDX_W-1:0]  lu_index,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pipe_stall,
  output logic [7:0]        squash_cnt
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int KILL_W = $clog2(DEPTH + 2);
  localparam int ST_W   = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [IDX_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              pipe_stall_q, pipe_stall_d;
  logic [SQ_W-1:0]   squash_q, squash_d;
  logic [SQ_W:0]     squash_sum;

  logic              full, empty, head_dead;
  logic [CNT_W-1:0]  count, occ_next;
  logic [IDX_W-1:0]  head_index;
  logic [DATA_W-1:0] head_data;
  logic [KILL_W-1:0] kill_cnt;
  logic              push, pop, head_live, blocked;

  assign lu_ready  = !full;
  assign push      = lu_valid && !full;
  assign head_live = !empty && !head_dead;
  // Dead heads retire without the port, so they never wait on the pipeline.
  assign pop       = !empty && (head_dead || !pipe_wb_en);
  assign blocked   = head_live && pipe_wb_en;
  assign occ_next  = count + CNT_W'(push) - CNT_W'(pop);

  wb_lu_buffer #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_index_i (lu_index),
    .push_data_i  (lu_data),
    .pop_i        (pop),
    .kill_i       (pipe_wb_en),
    .kill_index_i (pipe_wb_index),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .head_dead_o  (head_dead),
    .head_index_o (head_index),
    .head_data_o  (head_data),
    .kill_cnt_o   (kill_cnt)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (push) state_d = PENDING;
      end
      PENDING: begin
        if (pop) begin
          starve_d = '0;
        end else if (blocked) begin
          starve_d = starve_q + ST_W'(1);
          if (starve_q == ST_W'(STARVE_LIMIT - 1)) state_d = STARVED;
        end
      end
      STARVED: begin
        if (pop) begin
          starve_d = '0;
          state_d  = PENDING;
        end
      end
      default: state_d = IDLE;
    endcase
    if (occ_next == '0) begin
      state_d  = IDLE;
      starve_d = '0;
    end
    pipe_stall_d = (state_d == STARVED);
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_wb_en) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_wb_index;
      rf_wdata_d = pipe_wb_data;
    end else if (head_live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_index;
      rf_wdata_d = head_data;
    end
    squash_sum = (SQ_W+1)'(squash_q) + (SQ_W+1)'(kill_cnt);
    squash_d   = squash_sum[SQ_W] ? '1 : squash_sum[SQ_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pipe_stall_q <= 1'b0;
      squash_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pipe_stall_q <= pipe_stall_d;
      squash_q     <= squash_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = pipe_stall_q;
  assign squash_cnt = squash_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// at issue time and a negedge monitor pops and compares each observed write.
module tb_wb_port_arbiter;
  typedef struct {
    logic [5:0]  idx;
    logic [63:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        pipe_wb_en;
  logic [5:0]  pipe_wb_index;
  logic [63:0] pipe_wb_data;
  logic        lu_valid;
  logic [5:0]  lu_index;
  logic [63:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        pipe_stall;
  logic [7:0]  squash_cnt;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  wb_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_wb_en    (pipe_wb_en),
    .pipe_wb_index (pipe_wb_index),
    .pipe_wb_data  (pipe_wb_data),
    .lu_valid      (lu_valid),
    .lu_index      (lu_index),
    .lu_data       (lu_data),
    .lu_ready      (lu_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pipe_stall    (pipe_stall),
    .squash_cnt    (squash_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [5:0] idx, input logic [63:0] data);
    wr_t w;
    w.idx  = idx;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Pipeline writes are expected in issue order, so they are queued here.
  task automatic drive(input logic pe, input logic [5:0] pidx, input logic [63:0] pdata,
                       input logic lv, input logic [5:0] lidx, input logic [63:0] ldata);
    pipe_wb_en    = pe;
    pipe_wb_index = pidx;
    pipe_wb_data  = pdata;
    lu_valid      = lv;
    lu_index      = lidx;
    lu_data       = ldata;
    if (pe) exp_push(pidx, pdata);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      wr_t w;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got idx=%0d data=0x%0h required no write", rf_waddr, rf_wdata);
      end else begin
        w = exp_q.pop_front();
        if (rf_waddr !== w.idx || rf_wdata !== w.data) begin
          n_err++;
          $display("FAIL rf_write: got idx=%0d data=0x%0h required idx=%0d data=0x%0h",
                   rf_waddr, rf_wdata, w.idx, w.data);
        end else begin
          $display("ok   rf_write: idx=%0d data=0x%0h", rf_waddr, rf_wdata);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"},      64'(rf_we), 64'd0);
    check({tag, "_rf_waddr"},   64'(rf_waddr), 64'd0);
    check({tag, "_rf_wdata"},   rf_wdata, 64'd0);
    check({tag, "_pipe_stall"}, 64'(pipe_stall), 64'd0);
    check({tag, "_squash_cnt"}, 64'(squash_cnt), 64'd0);
    check({tag, "_lu_ready"},   64'(lu_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lone LU result, idle pipeline: written two edges after handshake.
    drive(1'b0, 6'd0, 64'd0, 1'b1, 6'd5, 64'hAA);
    exp_push(6'd5, 64'hAA);
    check("s1_lu_ready", 64'(lu_ready), 64'd1);
    tick();
    drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    check("s1_we_after_1", 64'(rf_we), 64'd0);
    tick();
    check("s1_we_after_2", 64'(rf_we), 64'd1);
    check("s1_waddr", 64'(rf_waddr), 64'd5);
    tick();
    check("s1_we_after_3", 64'(rf_we), 64'd0);

    // Pipe and LU in the same cycle: pipe first, LU on the next free slot.
    drive(1'b1, 6'd3, 64'h11, 1'b1, 6'd7, 64'h77);
    exp_push(6'd7, 64'h77);
    tick();
    drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    check("s2_waddr_pipe", 64'(rf_waddr), 64'd3);
    check("s2_wdata_pipe", rf_wdata, 64'h11);
    tick();
    check("s2_waddr_lu", 64'(rf_waddr), 64'd7);
    check("s2_wdata_lu", rf_wdata, 64'h77);
    tick();

    // Fill buffer under continuous pipe writes until starvation.
    drive(1'b1, 6'd10, 64'h1010, 1'b1, 6'd20, 64'h2020);
    tick();
    drive(1'b1, 6'd11, 64'h1111, 1'b1, 6'd21, 64'h2121);
    check("s3_ready_before_full", 64'(lu_ready), 64'd1);
    tick();
    check("s3_ready_full", 64'(lu_ready), 64'd0);
    drive(1'b1, 6'd12, 64'h1212, 1'b0, 6'd0, 64'd0);
    tick();
    drive(1'b1, 6'd13, 64'h1313, 1'b0, 6'd0, 64'd0);
    tick();
    check("s3_stall_after_3", 64'(pipe_stall), 64'd0);
    drive(1'b1, 6'd14, 64'h1414, 1'b0, 6'd0, 64'd0);
    tick();
    check("s3_stall_after_4", 64'(pipe_stall), 64'd1);
    drive(1'b1, 6'd15, 64'h1515, 1'b0, 6'd0, 64'd0);
    tick();
    check("s3_stall_held", 64'(pipe_stall), 64'd1);
    check("s3_pipe_wins", 64'(rf_waddr), 64'd15);
    exp_push(6'd20, 64'h2020);
    exp_push(6'd21, 64'h2121);
    drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    tick();
    check("s3_stall_cleared", 64'(pipe_stall), 64'd0);
    check("s3_head_waddr", 64'(rf_waddr), 64'd20);
    tick();
    check("s3_second_waddr", 64'(rf_waddr), 64'd21);
    check("s3_ready_again", 64'(lu_ready), 64'd1);
    tick();
    check("s3_idle_we", 64'(rf_we), 64'd0);

    // Buffered LU result killed by a younger pipe write to the same index.
    drive(1'b0, 6'd0, 64'd0, 1'b1, 6'd9, 64'h99);
    tick();
    drive(1'b1, 6'd9, 64'h22, 1'b0, 6'd0, 64'd0);
    tick();
    drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    check("s4_squash_cnt", 64'(squash_cnt), 64'd1);
    check("s4_wdata", rf_wdata, 64'h22);
    tick();
    check("s4_dead_pop_we", 64'(rf_we), 64'd0);
    tick();
    check("s4_drained_we", 64'(rf_we), 64'd0);

    // Same-cycle pipe and LU to one index: LU is stored dead.
    drive(1'b1, 6'd4, 64'h44, 1'b1, 6'd4, 64'h45);
    tick();
    drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    check("s5_squash_cnt", 64'(squash_cnt), 64'd2);
    check("s5_wdata", rf_wdata, 64'h44);
    tick();
    check("s5_dead_pop_we", 64'(rf_we), 64'd0);
    tick();

    // Async reset with a full, starved buffer.
    drive(1'b1, 6'd30, 64'h3030, 1'b1, 6'd40, 64'h4040);
    tick();
    drive(1'b1, 6'd31, 64'h3131, 1'b1, 6'd41, 64'h4141);
    tick();
    for (int i = 32; i <= 34; i++) begin
      drive(1'b1, 6'(i), 64'(i), 1'b0, 6'd0, 64'd0);
      tick();
    end
    check("s6_stall_before_rst", 64'(pipe_stall), 64'd1);
    check("s6_full_before_rst", 64'(lu_ready), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_async");
    drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) tick();
    check("s6_no_write_after_release", 64'(rf_we), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
